// File: rtl/aes_block_sequencer_pkg.sv
// Shared types and constants for the AES job sequencer.
// Imported by the sequencer top and its helpers.
package aes_block_sequencer_pkg;

   typedef enum logic {
      AES_MODE_ECB = 1'b0,
      AES_MODE_CBC = 1'b1
   } aes_mode_t;

   typedef enum logic [2:0] {
      SEQ_IDLE,
      SEQ_LOAD,
      SEQ_CORE_WAIT,
      SEQ_SEND,
      SEQ_FINISH
   } aes_seq_state_t;

   localparam int unsigned AES_BLOCK_BYTES = 16;
   localparam logic [1:0]  AES_KEY_INVALID = 2'b11;

endpackage

// File: rtl/aes_prefetch_reg.sv
// One-entry valid/ready holding register with synchronous clear.
// Holds the next input block while the current one is in flight.
module aes_prefetch_reg #(
   parameter int unsigned W = 128
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clear_i,
   input  logic [W-1:0] in_data_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   output logic [W-1:0] out_data_o,
   output logic         out_valid_o,
   input  logic         out_ready_i
);

   assign in_ready_o = !out_valid_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_valid_o <= 1'b0;
         out_data_o  <= '0;
      end else if (clear_i) begin
         out_valid_o <= 1'b0;
         out_data_o  <= '0;
      end else if (in_valid_i && !out_valid_o) begin
         out_valid_o <= 1'b1;
         out_data_o  <= in_data_i;
      end else if (out_ready_i && out_valid_o) begin
         out_valid_o <= 1'b0;
      end
   end

endmodule

// File: rtl/aes_block_sequencer.sv
// Engine-side AES job sequencer: streams blocks through the round core
// in ECB or CBC-encrypt mode with an optional one-block prefetch.
module aes_block_sequencer
   import aes_block_sequencer_pkg::*;
#(
   parameter int unsigned BLOCK_W  = 128,
   parameter int unsigned LEN_W    = 32,
   parameter int unsigned PREFETCH = 1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               clear_i,
   input  logic               start_i,
   input  logic [LEN_W-1:0]   data_size_i,
   input  logic [1:0]         key_size_i,
   input  logic               mode_i,
   input  logic [BLOCK_W-1:0] iv_i,
   input  logic [BLOCK_W-1:0] in_data_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   output logic               core_start_o,
   output logic [BLOCK_W-1:0] core_data_o,
   output logic [1:0]         core_key_size_o,
   input  logic               core_done_i,
   input  logic [BLOCK_W-1:0] core_data_i,
   output logic [BLOCK_W-1:0] out_data_o,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic               busy_o,
   output logic               done_o,
   output logic               error_o,
   output logic [LEN_W-1:0]   blocks_done_o
);

   localparam int unsigned SHIFT = $clog2(AES_BLOCK_BYTES);

   aes_seq_state_t     state_q;
   aes_mode_t          mode_q;
   logic [LEN_W-1:0]   total_q;
   logic [LEN_W-1:0]   fetched_q;
   logic [BLOCK_W-1:0] chain_q;

   logic               pf_valid;
   logic               pf_in_ready;
   logic [BLOCK_W-1:0] pf_data;
   logic               fetch_st;
   logic               in_hs;
   logic               pf_push;
   logic               pf_pop;
   logic               blk_avail;
   logic [BLOCK_W-1:0] blk;
   logic               cfg_bad;
   logic [LEN_W-1:0]   new_total;

   // Fetch in LOAD, or ahead of time while the core/output is busy.
   assign fetch_st = (state_q == SEQ_LOAD) ||
                     ((PREFETCH != 0) &&
                      ((state_q == SEQ_CORE_WAIT) ||
                       (state_q == SEQ_SEND)));
   assign in_ready_o = fetch_st && pf_in_ready && !clear_i &&
                       (fetched_q != total_q);
   assign in_hs     = in_valid_i && in_ready_o;
   assign pf_push   = in_hs && (state_q != SEQ_LOAD);
   assign pf_pop    = (state_q == SEQ_LOAD);
   assign blk_avail = pf_valid || in_hs;
   assign blk       = pf_valid ? pf_data : in_data_i;
   assign new_total = data_size_i >> SHIFT;
   assign cfg_bad   = (|data_size_i[SHIFT-1:0]) ||
                      (key_size_i == AES_KEY_INVALID);

   generate
      if (PREFETCH != 0) begin : g_pf
         aes_prefetch_reg #(
            .W (BLOCK_W)
         ) u_pf (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .clear_i     (clear_i),
            .in_data_i   (in_data_i),
            .in_valid_i  (pf_push),
            .in_ready_o  (pf_in_ready),
            .out_data_o  (pf_data),
            .out_valid_o (pf_valid),
            .out_ready_i (pf_pop)
         );
      end else begin : g_no_pf
         assign pf_valid    = 1'b0;
         assign pf_in_ready = 1'b1;
         assign pf_data     = '0;
      end
   endgenerate

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q         <= SEQ_IDLE;
         mode_q          <= AES_MODE_ECB;
         total_q         <= '0;
         fetched_q       <= '0;
         chain_q         <= '0;
         core_start_o    <= 1'b0;
         core_data_o     <= '0;
         core_key_size_o <= '0;
         out_data_o      <= '0;
         out_valid_o     <= 1'b0;
         busy_o          <= 1'b0;
         done_o          <= 1'b0;
         error_o         <= 1'b0;
         blocks_done_o   <= '0;
      end else if (clear_i) begin
         state_q         <= SEQ_IDLE;
         mode_q          <= AES_MODE_ECB;
         total_q         <= '0;
         fetched_q       <= '0;
         chain_q         <= '0;
         core_start_o    <= 1'b0;
         core_data_o     <= '0;
         core_key_size_o <= '0;
         out_data_o      <= '0;
         out_valid_o     <= 1'b0;
         busy_o          <= 1'b0;
         done_o          <= 1'b0;
         error_o         <= 1'b0;
         blocks_done_o   <= '0;
      end else begin
         core_start_o <= 1'b0;
         done_o       <= 1'b0;
         if (in_hs) fetched_q <= fetched_q + LEN_W'(1);
         unique case (state_q)
            SEQ_IDLE: begin
               if (start_i) begin
                  mode_q          <= aes_mode_t'(mode_i);
                  core_key_size_o <= key_size_i;
                  total_q         <= new_total;
                  chain_q         <= iv_i;
                  fetched_q       <= '0;
                  blocks_done_o   <= '0;
                  error_o         <= cfg_bad;
                  if (cfg_bad || (new_total == '0)) begin
                     done_o  <= 1'b1;
                     state_q <= SEQ_FINISH;
                  end else begin
                     busy_o  <= 1'b1;
                     state_q <= SEQ_LOAD;
                  end
               end
            end
            SEQ_LOAD: begin
               if (blk_avail) begin
                  core_start_o <= 1'b1;
                  core_data_o  <= (mode_q == AES_MODE_CBC) ?
                                  (blk ^ chain_q) : blk;
                  state_q      <= SEQ_CORE_WAIT;
               end
            end
            SEQ_CORE_WAIT: begin
               if (core_done_i) begin
                  out_data_o  <= core_data_i;
                  out_valid_o <= 1'b1;
                  if (mode_q == AES_MODE_CBC) chain_q <= core_data_i;
                  state_q     <= SEQ_SEND;
               end
            end
            SEQ_SEND: begin
               if (out_ready_i) begin
                  out_valid_o   <= 1'b0;
                  blocks_done_o <= blocks_done_o + LEN_W'(1);
                  if (blocks_done_o + LEN_W'(1) == total_q) begin
                     done_o  <= 1'b1;
                     busy_o  <= 1'b0;
                     state_q <= SEQ_FINISH;
                  end else begin
                     state_q <= SEQ_LOAD;
                  end
               end
            end
            SEQ_FINISH: state_q <= SEQ_IDLE;
            default:    state_q <= SEQ_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Directed bench for the AES job sequencer with a behavioural core.
module tb_aes_block_sequencer;

   localparam int BW = 128;
   localparam int LW = 32;

   localparam logic [BW-1:0] CBC_IV  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [BW-1:0] CBC_PT0 = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam logic [BW-1:0] CBC_PT1 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
   localparam logic [BW-1:0] CBC_IN0 = 128'h6bc0bce12a459991e134741a7f9e1925;
   localparam logic [BW-1:0] CBC_IN1 = 128'hd86421fb9f1a1eda505ee1375746972c;
   localparam logic [BW-1:0] CBC_CT0 = 128'h7649abac8119b246cee98e9b12e9197d;
   localparam logic [BW-1:0] CBC_CT1 = 128'h5086cb9b507219ee95db113a917678b2;

   logic          clk = 1'b0;
   logic          rst_ni = 1'b0;
   logic          clear_i = 1'b0;
   logic          start_i = 1'b0;
   logic [LW-1:0] data_size_i = '0;
   logic [1:0]    key_size_i = '0;
   logic          mode_i = 1'b0;
   logic [BW-1:0] iv_i = '0;
   logic [BW-1:0] in_data_i;
   logic          in_valid_i;
   logic          in_ready_o;
   logic          core_start_o;
   logic [BW-1:0] core_data_o;
   logic [1:0]    core_key_size_o;
   logic          core_done_i;
   logic [BW-1:0] core_data_i;
   logic [BW-1:0] out_data_o;
   logic          out_valid_o;
   logic          out_ready_i = 1'b1;
   logic          busy_o;
   logic          done_o;
   logic          error_o;
   logic [LW-1:0] blocks_done_o;

   int checks = 0;
   int errors = 0;

   int n_start = 0;
   int n_in = 0;
   int n_out = 0;
   int n_done = 0;
   logic [BW-1:0] core_log [64];
   logic [BW-1:0] out_log [64];

   logic [BW-1:0] src_mem [64];
   int src_ptr = 0;
   int src_n = 0;

   int core_lat = 3;
   logic core_mode = 1'b0;

   always #5 clk = ~clk;

   aes_block_sequencer #(
      .BLOCK_W  (BW),
      .LEN_W    (LW),
      .PREFETCH (1)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_ni),
      .clear_i         (clear_i),
      .start_i         (start_i),
      .data_size_i     (data_size_i),
      .key_size_i      (key_size_i),
      .mode_i          (mode_i),
      .iv_i            (iv_i),
      .in_data_i       (in_data_i),
      .in_valid_i      (in_valid_i),
      .in_ready_o      (in_ready_o),
      .core_start_o    (core_start_o),
      .core_data_o     (core_data_o),
      .core_key_size_o (core_key_size_o),
      .core_done_i     (core_done_i),
      .core_data_i     (core_data_i),
      .out_data_o      (out_data_o),
      .out_valid_o     (out_valid_o),
      .out_ready_i     (out_ready_i),
      .busy_o          (busy_o),
      .done_o          (done_o),
      .error_o         (error_o),
      .blocks_done_o   (blocks_done_o)
   );

   // Input source: offers queued blocks in order.
   assign in_valid_i = (src_ptr != src_n);
   assign in_data_i  = src_mem[src_ptr % 64];

   always @(posedge clk) begin
      if (in_valid_i && in_ready_o) src_ptr <= src_ptr + 1;
   end

   // Transfer monitor.
   always @(posedge clk) begin
      if (core_start_o === 1'b1) begin
         core_log[n_start % 64] = core_data_o;
         n_start++;
      end
      if (in_valid_i === 1'b1 && in_ready_o === 1'b1) n_in++;
      if (out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
         out_log[n_out % 64] = out_data_o;
         n_out++;
      end
      if (done_o === 1'b1) n_done++;
   end

   function automatic logic [BW-1:0] cbc_map(input logic [BW-1:0] d);
      if (d == CBC_IN0) return CBC_CT0;
      if (d == CBC_IN1) return CBC_CT1;
      return '0;
   endfunction

   // Behavioural core: echo+1, or the AES reference results in CBC mode.
   initial begin
      logic [BW-1:0] cd;
      core_done_i = 1'b0;
      core_data_i = '0;
      forever begin
         @(posedge clk);
         if (core_start_o === 1'b1) begin
            cd = core_data_o;
            repeat (core_lat - 1) @(posedge clk);
            #1;
            core_done_i = 1'b1;
            core_data_i = core_mode ? cbc_map(cd) : cd + 128'd1;
            @(posedge clk);
            #1;
            core_done_i = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [BW-1:0] b);
      src_mem[src_n % 64] = b;
      src_n++;
   endtask

   task automatic start_job(input logic [LW-1:0] size, input logic [1:0] key,
                            input logic mode, input logic [BW-1:0] iv);
      data_size_i = size;
      key_size_i  = key;
      mode_i      = mode;
      iv_i        = iv;
      start_i     = 1'b1;
      tick();
      start_i     = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name);
      int k;
      k = 0;
      while (done_o !== 1'b1 && k < budget) begin
         tick();
         k++;
      end
      checks++;
      if (done_o !== 1'b1) begin
         errors++;
         $display("FAIL %s: done_o=%b after %0d cycles, required 1", name, done_o, budget);
      end else begin
         checks++;
         if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy: busy_o=%b at done, required 0", name, busy_o);
         end
         tick();
         checks++;
         if (done_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_pulse: done_o=%b one cycle later, required 0", name, done_o);
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) tick();
      checks++;
      if ({busy_o, done_o, error_o, in_ready_o, out_valid_o, core_start_o} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b, required 000000",
                  {busy_o, done_o, error_o, in_ready_o, out_valid_o, core_start_o});
      end
      checks++;
      if (blocks_done_o !== '0 || out_data_o !== '0 || core_data_o !== '0) begin
         errors++;
         $display("FAIL reset_data: blocks_done=%0d out=%h core=%h, required 0",
                  blocks_done_o, out_data_o, core_data_o);
      end
      rst_ni = 1'b1;
      tick();
      checks++;
      if (busy_o !== 1'b0 || in_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: busy=%b in_ready=%b, required 0 0", busy_o, in_ready_o);
      end
   endtask

   task automatic test_ecb();
      logic [BW-1:0] blk [3];
      int s0, o0, d0;
      blk[0] = 128'h00112233445566778899aabbccddeeff;
      blk[1] = 128'h0123456789abcdef0123456789abcdef;
      blk[2] = 128'hffffffffffffffffffffffffffffffff;
      core_mode = 1'b0;
      core_lat  = 3;
      s0 = n_start;
      o0 = n_out;
      d0 = n_done;
      for (int i = 0; i < 3; i++) offer(blk[i]);
      start_job(48, 2'd0, 1'b0, '0);
      checks++;
      if (busy_o !== 1'b1) begin
         errors++;
         $display("FAIL ecb_busy: busy_o=%b after start, required 1", busy_o);
      end
      wait_done(300, "ecb_done");
      checks++;
      if (n_out - o0 != 3) begin
         errors++;
         $display("FAIL ecb_nout: got %0d outputs, required 3", n_out - o0);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (out_log[(o0 + i) % 64] !== blk[i] + 128'd1) begin
            errors++;
            $display("FAIL ecb_out%0d: got %h, required %h", i,
                     out_log[(o0 + i) % 64], blk[i] + 128'd1);
         end
         checks++;
         if (core_log[(s0 + i) % 64] !== blk[i]) begin
            errors++;
            $display("FAIL ecb_core%0d: got %h, required %h", i,
                     core_log[(s0 + i) % 64], blk[i]);
         end
      end
      checks++;
      if (blocks_done_o !== 32'd3 || n_done - d0 != 1 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL ecb_end: blocks_done=%0d dones=%0d busy=%b, required 3 1 0",
                  blocks_done_o, n_done - d0, busy_o);
      end
   endtask

   task automatic test_cbc();
      int s0, o0;
      core_mode = 1'b1;
      core_lat  = 2;
      s0 = n_start;
      o0 = n_out;
      offer(CBC_PT0);
      offer(CBC_PT1);
      start_job(32, 2'd0, 1'b1, CBC_IV);
      wait_done(300, "cbc_done");
      checks++;
      if (core_log[s0 % 64] !== CBC_IN0) begin
         errors++;
         $display("FAIL cbc_core0: got %h, required %h", core_log[s0 % 64], CBC_IN0);
      end
      checks++;
      if (core_log[(s0 + 1) % 64] !== CBC_IN1) begin
         errors++;
         $display("FAIL cbc_core1: got %h, required %h", core_log[(s0 + 1) % 64], CBC_IN1);
      end
      checks++;
      if (out_log[o0 % 64] !== CBC_CT0 || out_log[(o0 + 1) % 64] !== CBC_CT1) begin
         errors++;
         $display("FAIL cbc_out: got %h %h, required %h %h", out_log[o0 % 64],
                  out_log[(o0 + 1) % 64], CBC_CT0, CBC_CT1);
      end
      checks++;
      if (blocks_done_o !== 32'd2) begin
         errors++;
         $display("FAIL cbc_count: blocks_done=%0d, required 2", blocks_done_o);
      end
      core_mode = 1'b0;
   endtask

   task automatic test_config_error();
      logic [LW-1:0] sizes [2];
      logic [1:0]    keys [2];
      logic [BW-1:0] x;
      int s0, i0, o0;
      sizes[0] = 32'd20;
      keys[0]  = 2'd0;
      sizes[1] = 32'd32;
      keys[1]  = 2'd3;
      for (int c = 0; c < 2; c++) begin
         s0 = n_start;
         i0 = n_in;
         start_job(sizes[c], keys[c], 1'b0, '0);
         checks++;
         if (in_ready_o !== 1'b0 || error_o !== 1'b1) begin
            errors++;
            $display("FAIL err%0d_flags: in_ready=%b error=%b, required 0 1",
                     c, in_ready_o, error_o);
         end
         wait_done(2, "err_done");
         checks++;
         if (n_start != s0 || n_in != i0 || error_o !== 1'b1) begin
            errors++;
            $display("FAIL err%0d_quiet: starts=%0d ins=%0d error=%b, required 0 0 1",
                     c, n_start - s0, n_in - i0, error_o);
         end
      end
      x  = 128'hdeadbeefcafebabe0011223344556677;
      o0 = n_out;
      offer(x);
      start_job(16, 2'd1, 1'b0, '0);
      checks++;
      if (error_o !== 1'b0) begin
         errors++;
         $display("FAIL err_clear: error_o=%b after valid start, required 0", error_o);
      end
      wait_done(200, "err_next_done");
      checks++;
      if (out_log[o0 % 64] !== x + 128'd1 || core_key_size_o !== 2'd1) begin
         errors++;
         $display("FAIL err_next: out=%h key=%0d, required %h 1",
                  out_log[o0 % 64], core_key_size_o, x + 128'd1);
      end
   endtask

   task automatic test_backpressure();
      logic [BW-1:0] blk [3];
      logic [BW-1:0] held;
      logic stable;
      int s0, i0, o0, k;
      blk[0] = 128'h10000000000000000000000000000001;
      blk[1] = 128'h20000000000000000000000000000002;
      blk[2] = 128'h30000000000000000000000000000003;
      core_lat = 2;
      s0 = n_start;
      i0 = n_in;
      o0 = n_out;
      for (int i = 0; i < 3; i++) offer(blk[i]);
      out_ready_i = 1'b0;
      start_job(48, 2'd2, 1'b0, '0);
      k = 0;
      while (out_valid_o !== 1'b1 && k < 50) begin
         tick();
         k++;
      end
      checks++;
      if (out_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL bp_valid: out_valid=%b after 50 cycles, required 1", out_valid_o);
      end
      held   = out_data_o;
      stable = 1'b1;
      repeat (10) begin
         tick();
         if (out_data_o !== held || out_valid_o !== 1'b1) stable = 1'b0;
      end
      checks++;
      if (stable !== 1'b1 || held !== blk[0] + 128'd1) begin
         errors++;
         $display("FAIL bp_hold: stable=%b data=%h, required 1 %h",
                  stable, held, blk[0] + 128'd1);
      end
      checks++;
      if (n_in - i0 != 2 || in_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL bp_prefetch: ins=%0d in_ready=%b, required 2 0",
                  n_in - i0, in_ready_o);
      end
      checks++;
      if (n_start - s0 != 1) begin
         errors++;
         $display("FAIL bp_launch: starts=%0d while stalled, required 1", n_start - s0);
      end
      out_ready_i = 1'b1;
      wait_done(300, "bp_done");
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (out_log[(o0 + i) % 64] !== blk[i] + 128'd1) begin
            errors++;
            $display("FAIL bp_out%0d: got %h, required %h", i,
                     out_log[(o0 + i) % 64], blk[i] + 128'd1);
         end
      end
      checks++;
      if (blocks_done_o !== 32'd3 || n_in - i0 != 3 || core_key_size_o !== 2'd2) begin
         errors++;
         $display("FAIL bp_end: blocks_done=%0d ins=%0d key=%0d, required 3 3 2",
                  blocks_done_o, n_in - i0, core_key_size_o);
      end
   endtask

   task automatic test_zero_len();
      int s0, i0, o0;
      s0 = n_start;
      i0 = n_in;
      o0 = n_out;
      start_job(0, 2'd0, 1'b0, '0);
      wait_done(2, "zero_done");
      checks++;
      if (n_start != s0 || n_in != i0 || n_out != o0) begin
         errors++;
         $display("FAIL zero_xfer: starts=%0d ins=%0d outs=%0d, required 0 0 0",
                  n_start - s0, n_in - i0, n_out - o0);
      end
      checks++;
      if (blocks_done_o !== '0 || error_o !== 1'b0) begin
         errors++;
         $display("FAIL zero_state: blocks_done=%0d error=%b, required 0 0",
                  blocks_done_o, error_o);
      end
   endtask

   task automatic test_clear();
      logic [BW-1:0] d, e;
      int s0, d0, o1, k;
      core_lat = 5;
      s0 = n_start;
      d0 = n_done;
      for (int i = 0; i < 4; i++) offer(128'h5000 + 128'(i));
      start_job(64, 2'd0, 1'b0, '0);
      k = 0;
      while (n_start - s0 < 2 && k < 100) begin
         tick();
         k++;
      end
      checks++;
      if (n_start - s0 != 2 || blocks_done_o !== 32'd1) begin
         errors++;
         $display("FAIL clr_reach: starts=%0d blocks_done=%0d, required 2 1",
                  n_start - s0, blocks_done_o);
      end
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      src_n = src_ptr;
      checks++;
      if ({busy_o, out_valid_o, in_ready_o, core_start_o, error_o} !== 5'b0 ||
          blocks_done_o !== '0) begin
         errors++;
         $display("FAIL clr_state: flags=%b blocks_done=%0d, required 00000 0",
                  {busy_o, out_valid_o, in_ready_o, core_start_o, error_o}, blocks_done_o);
      end
      o1 = n_out;
      repeat (8) tick();
      checks++;
      if (n_done != d0 || n_out != o1 || out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL clr_late: dones=%0d outs=%0d valid=%b busy=%b, required 0 0 0 0",
                  n_done - d0, n_out - o1, out_valid_o, busy_o);
      end
      d  = 128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5;
      e  = 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f;
      core_lat = 1;
      d0 = n_done;
      offer(d);
      offer(e);
      start_job(32, 2'd0, 1'b0, '0);
      wait_done(200, "clr_fresh_done");
      checks++;
      if (out_log[o1 % 64] !== d + 128'd1 || out_log[(o1 + 1) % 64] !== e + 128'd1) begin
         errors++;
         $display("FAIL clr_fresh_out: got %h %h, required %h %h", out_log[o1 % 64],
                  out_log[(o1 + 1) % 64], d + 128'd1, e + 128'd1);
      end
      checks++;
      if (blocks_done_o !== 32'd2 || n_done - d0 != 1) begin
         errors++;
         $display("FAIL clr_fresh_end: blocks_done=%0d dones=%0d, required 2 1",
                  blocks_done_o, n_done - d0);
      end
   endtask

   initial begin
      test_reset();
      test_ecb();
      test_cbc();
      test_config_error();
      test_backpressure();
      test_zero_len();
      test_clear();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
